// File: rtl/if_stage_pkg.sv
// Shared CPU constants and helpers used by the fetch stage and its IF/ID register.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction, inserts a NOP bubble,
// or holds, and counts every valid instruction it delivers.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                bubble_i,
    input  logic                hold_i,
    input  logic [31:0]         instr_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [PC_WIDTH-1:0] pc4_i,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc4_o,
    output logic                valid_o,
    output logic [15:0]         count_o
);

    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc4_q, pc4_d;
    logic                valid_q, valid_d;
    logic [15:0]         count_q, count_d;

    // A bubble wins over hold; its PC fields keep their old values since valid=0.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (bubble_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i && !hold_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
            count_d = sat_inc16(count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register with next-PC selection (advance, hold,
// redirect) feeding the IF/ID register; instruction memory sits outside.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                flush,
    output logic [PC_WIDTH-1:0] im_pc,
    input  logic [31:0]         im_instr,
    output logic [31:0]         id_instr,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [PC_WIDTH-1:0] id_pc4,
    output logic                id_valid,
    output logic                misalign_err,
    output logic [15:0]         fetch_count
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                misalign_q, misalign_d;
    logic                bubble;
    logic                load;

    assign pc_plus4 = pc_q + PC_WIDTH'(PC_STEP);
    assign bubble   = redirect | flush;
    assign load     = ~stall & ~bubble;

    // Redirect beats stall; the target is forced word-aligned.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect) begin
            pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign im_pc        = pc_q;
    assign misalign_err = misalign_q;

    if_id_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .bubble_i (bubble),
        .hold_i   (stall),
        .instr_i  (im_instr),
        .pc_i     (pc_q),
        .pc4_i    (pc_plus4),
        .instr_o  (id_instr),
        .pc_o     (id_pc),
        .pc4_o    (id_pc4),
        .valid_o  (id_valid),
        .count_o  (fetch_count)
    );

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_WIDTH, default 16, meaning the width of the PC.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the PC and the IF/ID register.
REQ-006 The block SHALL have port redirect, input, 1 bit: taken branch or jump.
REQ-007 The block SHALL have port redirect_pc, input, PC_WIDTH bits: the branch or jump target byte address.
REQ-008 The block SHALL have port flush, input, 1 bit: kill the instruction being latched into IF/ID.
REQ-009 The block SHALL have port im_pc, output, PC_WIDTH bits: the address driven to instruction memory.
REQ-010 The block SHALL have port im_instr, input, 32 bits: the instruction returned combinationally by instruction memory.
REQ-011 The block SHALL have port id_instr, output, 32 bits: the registered instruction.
REQ-012 The block SHALL have port id_pc, output, PC_WIDTH bits: the PC of id_instr.
REQ-013 The block SHALL have port id_pc4, output, PC_WIDTH bits: id_pc+4.
REQ-014 The block SHALL have port id_valid, output, 1 bit: id_instr is a real instruction.
REQ-015 The block SHALL have port misalign_err, output, 1 bit: sticky flag for a misaligned redirect target.
REQ-016 The block SHALL have port fetch_count, output, 16 bits: count of valid instructions delivered.

Function
REQ-017 im_pc SHALL equal the internal PC register combinationally, with zero latency.
REQ-018 The PC SHALL advance when neither stall nor redirect is asserted: pc <= pc+4, modulo 2^PC_WIDTH, so FFFC wraps to 0000.
REQ-019 On redirect, the PC SHALL load {redirect_pc[PC_WIDTH-1:2],2'b00}; redirect overrides stall.
REQ-020 With stall=1 and redirect=0, the PC and all id_* registers SHALL hold their values.
REQ-021 On an advance (stall=0, redirect=0, flush=0), the block SHALL register im_instr into id_instr, pc into id_pc and pc+4 into id_pc4, and set id_valid=1.
REQ-022 When redirect=1 or flush=1, the next id_valid SHALL be 0 and id_instr SHALL be NOP 32'h00000013; this bubble overrides stall.
REQ-023 Latency SHALL be one cycle from im_pc presenting address A to id_instr holding ROM[A].
REQ-024 misalign_err SHALL be set on any cycle with redirect=1 and redirect_pc[1:0]!=0, and is cleared only by reset.
REQ-025 fetch_count SHALL increment by 1 on each cycle that id_valid is loaded with 1, and saturate at 16'hFFFF.
REQ-026 Simultaneous redirect and flush SHALL behave as redirect.
REQ-027 A redirect to the current PC value SHALL still insert one bubble.

Reset
REQ-028 While rst_n=0, the block SHALL force pc=RESET_PC, id_instr=32'h00000013, id_pc=0, id_pc4=0, id_valid=0, misalign_err=0, fetch_count=0, regardless of clk.
REQ-029 After rst_n deasserts, the first rising edge SHALL latch ROM[RESET_PC] with id_valid=1, unless stall, redirect or flush is active.
REQ-030 A reset asserted mid-stall or mid-redirect SHALL discard the pending operation entirely.

Structure
REQ-031 The constants NOP_INSTR (32'h00000013) and PC_STEP (4) SHALL live in the shared CPU package.
REQ-032 The IF/ID pipeline register SHALL be a sub-module if_id_reg with load, bubble and hold controls; the PC register and next-PC mux stay in if_stage.
REQ-033 The block SHALL contain no memory; it connects to the existing instruction memory through im_pc and im_instr only.

Verification
REQ-034 Reset then free-run with ROM[0]=00c00513, ROM[4]=00900593, ROM[8]=40b50633: id_instr SHALL read 00c00513/00900593/40b50633 with id_pc 0/4/8, id_valid=1, and fetch_count=3.
REQ-035 Stall held 3 cycles at pc=8: im_pc SHALL stay 8, id_* SHALL be unchanged, and fetch_count SHALL not increment.
REQ-036 Redirect to 0x0004 while stall=1: next im_pc SHALL be 4 and id_valid=0 with id_instr=00000013; the following cycle id_instr SHALL be 00900593.
REQ-037 Redirect to 0x0006: im_pc SHALL become 4 and misalign_err SHALL be 1, remaining 1 after further redirects until rst_n pulses low.
REQ-038 With RESET_PC=16'hFFFC and free-run: im_pc SHALL go FFFC to 0000, and id_pc4 SHALL be 0000 for the FFFC fetch.
REQ-039 Assert rst_n=0 asynchronously between clock edges during a redirect: all outputs SHALL reach their reset values immediately, and the redirect target SHALL not be applied.
